// File: rtl/demux_switch_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_switch_if
// Purpose  : Bundle of the demux_switch input handshake, per-slot output
//            handshake and error flag.
//            slave  : view of the distributor itself
//            master : view of the producer / consumers driving it
// Ports    : data_in, S, in_valid, in_ready   - input word channel
//            data_out, out_valid, out_ready   - SIZE output slots
//            sel_err                          - sticky out-of-range flag
//            bcast (DEMUX_BROADCAST_EN only)  - write every slot
// Macro    : DEMUX_BROADCAST_EN adds the bcast signal
// Revision : 1.0 - initial release
// ============================================================================
interface demux_switch_if #(
   parameter int SIZE       = 8,
   parameter int DATA_WIDTH = 16
);
   localparam int SEL_WIDTH = $clog2(SIZE);

   logic [DATA_WIDTH-1:0]      data_in;
   logic [SEL_WIDTH-1:0]       S;
   logic                       in_valid;
   logic                       in_ready;
   logic [SIZE*DATA_WIDTH-1:0] data_out;
   logic [SIZE-1:0]            out_valid;
   logic [SIZE-1:0]            out_ready;
   logic                       sel_err;
`ifdef DEMUX_BROADCAST_EN
   logic                       bcast;

   modport slave (
      input  data_in, S, in_valid, out_ready, bcast,
      output in_ready, data_out, out_valid, sel_err
   );
   modport master (
      output data_in, S, in_valid, out_ready, bcast,
      input  in_ready, data_out, out_valid, sel_err
   );
`else
   modport slave (
      input  data_in, S, in_valid, out_ready,
      output in_ready, data_out, out_valid, sel_err
   );
   modport master (
      output data_in, S, in_valid, out_ready,
      input  in_ready, data_out, out_valid, sel_err
   );
`endif
endinterface
`default_nettype wire

// File: rtl/demux_switch.sv
`default_nettype none
// ============================================================================
// Module   : demux_switch
// Purpose  : Registered 1-to-SIZE word distributor. One word per clock is
//            accepted on a valid/ready input and written into output slot S;
//            each slot holds its word until its own consumer takes it.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous, active-high reset
//            bus    - demux_switch_if.slave (input channel, SIZE output
//                     slots, sticky sel_err)
// Macro    : DEMUX_BROADCAST_EN - when defined, bus.bcast=1 writes data_in to
//            every slot; the accept then waits until all slots are free.
// Revision : 1.0 - initial release
// ============================================================================
module demux_switch #(
   parameter int SIZE       = 8,
   parameter int DATA_WIDTH = 16
) (
   input wire logic      clk,
   input wire logic      reset,
   demux_switch_if.slave bus
);
   localparam int SEL_WIDTH = $clog2(SIZE);
   // One extra bit so SIZE itself is representable for the range compare.
   localparam logic [SEL_WIDTH:0] c_size = (SEL_WIDTH+1)'(SIZE);

   logic [SIZE-1:0]            w_sel_onehot;
   logic [SIZE-1:0]            w_slot_open;
   logic [SIZE-1:0]            w_load;
   logic [SIZE-1:0]            w_drain;
   logic                       w_in_range;
   logic                       w_uni_ready;
   logic                       w_ready;
   logic                       w_accept;
   logic                       w_err_set;

   logic [SIZE-1:0]            r_out_valid;
   logic [SIZE*DATA_WIDTH-1:0] r_data_out;
   logic                       r_sel_err;

   // Out-of-range S decodes to an all-zero one-hot, so no slot is touched.
   assign w_in_range = ({1'b0, bus.S} < c_size);

   for (genvar g = 0; g < SIZE; g++) begin : g_sel
      assign w_sel_onehot[g] = (bus.S == SEL_WIDTH'(g));
   end

   // A slot can take a word if it is empty or being drained this cycle.
   assign w_slot_open = ~r_out_valid | bus.out_ready;
   // Out-of-range words are always accepted (and dropped).
   assign w_uni_ready = ~w_in_range | (|(w_sel_onehot & w_slot_open));

`ifdef DEMUX_BROADCAST_EN
   assign w_ready   = ~reset & (bus.bcast ? (&w_slot_open) : w_uni_ready);
   assign w_accept  = bus.in_valid & w_ready;
   assign w_load    = {SIZE{w_accept}} &
                      (bus.bcast ? {SIZE{1'b1}} : w_sel_onehot);
   assign w_err_set = w_accept & ~bus.bcast & ~w_in_range;
`else
   assign w_ready   = ~reset & w_uni_ready;
   assign w_accept  = bus.in_valid & w_ready;
   assign w_load    = {SIZE{w_accept}} & w_sel_onehot;
   assign w_err_set = w_accept & ~w_in_range;
`endif

   // out_ready on an empty slot is masked out here.
   assign w_drain = r_out_valid & bus.out_ready;

   // A refill in the same cycle as a drain wins, keeping the slot valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= '0;
         r_sel_err   <= 1'b0;
      end else begin
         r_out_valid <= (r_out_valid & ~w_drain) | w_load;
         if (w_err_set) begin
            r_sel_err <= 1'b1;
         end
      end
   end

   // Slot data only changes on a load; a drain leaves the last word visible.
   for (genvar g = 0; g < SIZE; g++) begin : g_slot
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_data_out[g*DATA_WIDTH +: DATA_WIDTH] <= '0;
         end else if (w_load[g]) begin
            r_data_out[g*DATA_WIDTH +: DATA_WIDTH] <= bus.data_in;
         end
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.data_out  = r_data_out;
   assign bus.sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_demux_switch.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_switch
// Purpose  : Self-checking bench for demux_switch. dut_a uses SIZE=8 and is
//            tracked by a slot-array reference model; dut_b uses SIZE=6 for
//            the out-of-range selector behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_switch;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   demux_switch_if #(.SIZE(8), .DATA_WIDTH(16)) bus_a ();
   demux_switch_if #(.SIZE(6), .DATA_WIDTH(16)) bus_b ();

   demux_switch #(.SIZE(8), .DATA_WIDTH(16)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );
   demux_switch #(.SIZE(6), .DATA_WIDTH(16)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: what each slot of dut_a holds and whether it is full.
   logic [15:0] m_data [8];
   logic [7:0]  m_valid;

   // Inputs currently presented to dut_a.
   logic        cur_v;
   logic [2:0]  cur_s;
   logic [15:0] cur_d;
   logic [7:0]  cur_ordy;
   logic        cur_bc;

   function automatic void m_reset();
      m_valid = '0;
      for (int k = 0; k < 8; k++) m_data[k] = '0;
   endfunction

   function automatic logic m_ready();
      if (reset) return 1'b0;
      if (cur_bc) begin
         for (int k = 0; k < 8; k++)
            if (m_valid[k] && !cur_ordy[k]) return 1'b0;
         return 1'b1;
      end
      return !m_valid[cur_s] || cur_ordy[cur_s];
   endfunction

   function automatic void m_edge();
      logic acc;
      acc = cur_v && m_ready();
      for (int k = 0; k < 8; k++)
         if (m_valid[k] && cur_ordy[k]) m_valid[k] = 1'b0;
      if (acc) begin
         if (cur_bc) begin
            for (int k = 0; k < 8; k++) begin
               m_valid[k] = 1'b1;
               m_data[k]  = cur_d;
            end
         end else begin
            m_valid[cur_s] = 1'b1;
            m_data[cur_s]  = cur_d;
         end
      end
   endfunction

   function automatic logic [127:0] m_dout();
      logic [127:0] r;
      for (int k = 0; k < 8; k++) r[k*16 +: 16] = m_data[k];
      return r;
   endfunction

   task automatic apply(input logic v, input logic [2:0] s, input logic [15:0] d,
                        input logic [7:0] ordy, input logic bc);
      @(negedge clk);
      cur_v = v; cur_s = s; cur_d = d; cur_ordy = ordy; cur_bc = bc;
      bus_a.in_valid  = v;
      bus_a.S         = s;
      bus_a.data_in   = d;
      bus_a.out_ready = ordy;
`ifdef DEMUX_BROADCAST_EN
      bus_a.bcast     = bc;
`endif
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      apply(1'b1, 3'd2, 16'h1234, 8'h00, 1'b0);
      n_checks++; if (bus_a.in_ready !== 1'b0) begin n_fail++;
         $display("FAIL por_in_ready got=%b exp=0", bus_a.in_ready); end
      n_checks++; if (bus_a.out_valid !== 8'h00) begin n_fail++;
         $display("FAIL por_out_valid got=%h exp=00", bus_a.out_valid); end
      apply(1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
      reset = 1'b0;
      m_reset();
      apply(1'b1, 3'd2, 16'h2222, 8'h00, 1'b0); tick();
      apply(1'b1, 3'd5, 16'h5555, 8'h00, 1'b0); tick();
      n_checks++; if (bus_a.out_valid !== 8'h24) begin n_fail++;
         $display("FAIL fill_2_5 got=%h exp=24", bus_a.out_valid); end
      // Reset asserted between clock edges must take effect immediately.
      apply(1'b1, 3'd1, 16'h7777, 8'h00, 1'b0);
      #2 reset = 1'b1;
      #1;
      n_checks++; if (bus_a.out_valid !== 8'h00) begin n_fail++;
         $display("FAIL async_out_valid got=%h exp=00", bus_a.out_valid); end
      n_checks++; if (bus_a.data_out !== 128'h0) begin n_fail++;
         $display("FAIL async_data_out got=%h exp=0", bus_a.data_out); end
      n_checks++; if (bus_a.sel_err !== 1'b0) begin n_fail++;
         $display("FAIL async_sel_err got=%b exp=0", bus_a.sel_err); end
      n_checks++; if (bus_a.in_ready !== 1'b0) begin n_fail++;
         $display("FAIL async_in_ready got=%b exp=0", bus_a.in_ready); end
      m_reset();
      apply(1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_unicast_sweep();
      logic [15:0] w;
      for (int s = 0; s < 8; s++) begin
         w = (s == 7) ? 16'h0108 : 16'((s + 1) * 16'h0110);
         apply(1'b1, 3'(s), w, 8'h00, 1'b0);
         n_checks++; if (bus_a.in_ready !== 1'b1) begin n_fail++;
            $display("FAIL sweep_in_ready s=%0d got=%b exp=1", s, bus_a.in_ready); end
         tick();
         n_checks++; if (bus_a.out_valid[s] !== 1'b1) begin n_fail++;
            $display("FAIL sweep_valid s=%0d got=%b exp=1", s, bus_a.out_valid[s]); end
         n_checks++; if (bus_a.data_out[s*16 +: 16] !== w) begin n_fail++;
            $display("FAIL sweep_data s=%0d got=%h exp=%h", s, bus_a.data_out[s*16 +: 16], w); end
      end
      apply(1'b0, 3'd0, 16'h0000, 8'h00, 1'b0); tick();
      n_checks++; if (bus_a.out_valid !== 8'hFF) begin n_fail++;
         $display("FAIL sweep_final got=%h exp=FF", bus_a.out_valid); end
   endtask

   task automatic test_backpressure();
      apply(1'b1, 3'd3, 16'h0BEE, 8'h00, 1'b0);
      n_checks++; if (bus_a.in_ready !== 1'b0) begin n_fail++;
         $display("FAIL bp_blocked got=%b exp=0", bus_a.in_ready); end
      tick();
      n_checks++; if (bus_a.data_out[3*16 +: 16] !== 16'h0440) begin n_fail++;
         $display("FAIL bp_hold got=%h exp=0440", bus_a.data_out[3*16 +: 16]); end
      apply(1'b1, 3'd3, 16'h0BEE, 8'h08, 1'b0);
      n_checks++; if (bus_a.in_ready !== 1'b1) begin n_fail++;
         $display("FAIL bp_release got=%b exp=1", bus_a.in_ready); end
      tick();
      n_checks++; if (bus_a.data_out[3*16 +: 16] !== 16'h0BEE) begin n_fail++;
         $display("FAIL bp_refill got=%h exp=0BEE", bus_a.data_out[3*16 +: 16]); end
      n_checks++; if (bus_a.out_valid !== 8'hFF) begin n_fail++;
         $display("FAIL bp_valid got=%h exp=FF", bus_a.out_valid); end
   endtask

   task automatic test_independent_drains();
      logic [127:0] held;
      apply(1'b0, 3'd0, 16'h0000, 8'hFF, 1'b0); tick();
      n_checks++; if (bus_a.out_valid !== 8'h00) begin n_fail++;
         $display("FAIL drain_all got=%h exp=00", bus_a.out_valid); end
      n_checks++; if (bus_a.data_out !== m_dout()) begin n_fail++;
         $display("FAIL drain_all_data got=%h exp=%h", bus_a.data_out, m_dout()); end
      apply(1'b1, 3'd0, 16'h0A0A, 8'h00, 1'b0); tick();
      apply(1'b1, 3'd1, 16'h1B1B, 8'h00, 1'b0); tick();
      apply(1'b1, 3'd4, 16'h4C4C, 8'h00, 1'b0); tick();
      n_checks++; if (bus_a.out_valid !== 8'h13) begin n_fail++;
         $display("FAIL drain_fill got=%h exp=13", bus_a.out_valid); end
      held = bus_a.data_out;
      apply(1'b0, 3'd0, 16'h0000, 8'h13, 1'b0); tick();
      n_checks++; if (bus_a.out_valid !== 8'h00) begin n_fail++;
         $display("FAIL drain_013 got=%h exp=00", bus_a.out_valid); end
      n_checks++; if (bus_a.data_out !== held || bus_a.data_out[4*16 +: 16] !== 16'h4C4C) begin
         n_fail++;
         $display("FAIL drain_013_data got=%h exp=%h", bus_a.data_out, held); end
   endtask

   task automatic test_range_error();
      logic [95:0] exp_b;
      apply(1'b0, 3'd0, 16'h0000, 8'h00, 1'b0); tick();
      exp_b = '0;
      exp_b[2*16 +: 16] = 16'h2B2B;
      @(negedge clk);
      bus_b.in_valid = 1'b1; bus_b.S = 3'd2; bus_b.data_in = 16'h2B2B; bus_b.out_ready = 6'h00;
      @(posedge clk); #1;
      n_checks++; if (bus_b.out_valid !== 6'h04 || bus_b.sel_err !== 1'b0) begin n_fail++;
         $display("FAIL rng_load got=%h/%b exp=04/0", bus_b.out_valid, bus_b.sel_err); end
      @(negedge clk);
      bus_b.S = 3'd7; bus_b.data_in = 16'hDEAD;
      #1;
      n_checks++; if (bus_b.in_ready !== 1'b1) begin n_fail++;
         $display("FAIL rng_ready got=%b exp=1", bus_b.in_ready); end
      @(posedge clk); #1;
      n_checks++; if (bus_b.sel_err !== 1'b1) begin n_fail++;
         $display("FAIL rng_err got=%b exp=1", bus_b.sel_err); end
      n_checks++; if (bus_b.out_valid !== 6'h04 || bus_b.data_out !== exp_b) begin n_fail++;
         $display("FAIL rng_slots got=%h/%h exp=04/%h", bus_b.out_valid, bus_b.data_out, exp_b); end
      @(negedge clk);
      bus_b.S = 3'd1; bus_b.data_in = 16'h1111; bus_b.out_ready = 6'h04;
      @(posedge clk); #1;
      n_checks++; if (bus_b.sel_err !== 1'b1 || bus_b.out_valid !== 6'h02) begin n_fail++;
         $display("FAIL rng_sticky got=%b/%h exp=1/02", bus_b.sel_err, bus_b.out_valid); end
      @(negedge clk);
      bus_b.in_valid = 1'b0; bus_b.out_ready = 6'h00;
      reset = 1'b1;
      #1;
      n_checks++; if (bus_b.sel_err !== 1'b0) begin n_fail++;
         $display("FAIL rng_clear got=%b exp=0", bus_b.sel_err); end
      m_reset();
      #1 reset = 1'b0;
   endtask

`ifdef DEMUX_BROADCAST_EN
   task automatic test_broadcast();
      apply(1'b1, 3'd0, 16'hA5A5, 8'h00, 1'b1);
      n_checks++; if (bus_a.in_ready !== 1'b1) begin n_fail++;
         $display("FAIL bc_ready got=%b exp=1", bus_a.in_ready); end
      tick();
      n_checks++; if (bus_a.out_valid !== 8'hFF || bus_a.data_out !== {8{16'hA5A5}}) begin
         n_fail++;
         $display("FAIL bc_fill got=%h/%h exp=FF/all A5A5", bus_a.out_valid, bus_a.data_out); end
      apply(1'b0, 3'd0, 16'h0000, 8'hBF, 1'b0); tick();
      apply(1'b1, 3'd2, 16'h5A5A, 8'h00, 1'b1);
      n_checks++; if (bus_a.in_ready !== 1'b0) begin n_fail++;
         $display("FAIL bc_blocked got=%b exp=0", bus_a.in_ready); end
      tick();
      n_checks++; if (bus_a.out_valid !== 8'h40 || bus_a.data_out !== {8{16'hA5A5}}) begin
         n_fail++;
         $display("FAIL bc_hold got=%h/%h exp=40/all A5A5", bus_a.out_valid, bus_a.data_out); end
   endtask
`endif

   task automatic test_random();
      logic bc;
      logic exp_rdy;
      for (int i = 0; i < 400; i++) begin
`ifdef DEMUX_BROADCAST_EN
         bc = ($urandom_range(0, 7) == 0);
`else
         bc = 1'b0;
`endif
         apply($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
               8'($urandom), bc);
         exp_rdy = m_ready();
         n_checks++; if (bus_a.in_ready !== exp_rdy) begin n_fail++;
            $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, bus_a.in_ready, exp_rdy); end
         tick();
         n_checks++; if (bus_a.out_valid !== m_valid) begin n_fail++;
            $display("FAIL rnd_valid cyc=%0d got=%h exp=%h", i, bus_a.out_valid, m_valid); end
         n_checks++; if (bus_a.data_out !== m_dout()) begin n_fail++;
            $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, bus_a.data_out, m_dout()); end
         n_checks++; if (bus_a.sel_err !== 1'b0) begin n_fail++;
            $display("FAIL rnd_sel_err cyc=%0d got=%b exp=0", i, bus_a.sel_err); end
      end
   endtask

   initial begin
      reset = 1'b1;
      cur_v = 1'b0; cur_s = '0; cur_d = '0; cur_ordy = '0; cur_bc = 1'b0;
      bus_a.in_valid = 1'b0; bus_a.S = '0; bus_a.data_in = '0; bus_a.out_ready = '0;
      bus_b.in_valid = 1'b0; bus_b.S = '0; bus_b.data_in = '0; bus_b.out_ready = '0;
`ifdef DEMUX_BROADCAST_EN
      bus_a.bcast = 1'b0;
      bus_b.bcast = 1'b0;
`endif
      m_reset();
      test_reset();
      test_unicast_sweep();
      test_backpressure();
      test_independent_drains();
      test_range_error();
`ifdef DEMUX_BROADCAST_EN
      test_broadcast();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
